// File: rtl/score_uart_tx.sv
// score_uart_tx: watches the Ninety-Nine game state and BCD score and streams
// ASCII event messages ("GO x\r\n", "SCORE dd\r\n") into the board UART.
// The message in flight is fixed at event time. One pending slot holds an event
// that arrives during a message; a newer event replaces it and pulses overrun.
// Build option: define NINETYNINE_LEVEL_ECHO_EN to also report play -> play
// letter changes as "x\r\n".
module score_uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [7:0] score,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} fsm_t;
  typedef enum logic [1:0] {K_START = 2'd0, K_END = 2'd1, K_ECHO = 2'd2} kind_t;

  // c0/c1 hold the only bytes that vary per message: the letter for START/ECHO,
  // or the tens/units characters for END.
  typedef struct packed {
    kind_t      kind;
    logic [7:0] c0;
    logic [7:0] c1;
  } msg_t;

  localparam logic [2:0] ST_PRE  = 3'b000;
  localparam logic [2:0] ST_OVER = 3'b111;

  fsm_t       r_fsm, w_fsm_nxt;
  logic [3:0] r_idx, w_idx_nxt;
  msg_t       r_cur, w_cur_nxt;
  msg_t       r_pend, w_pend_nxt;
  logic       r_pend_v, w_pend_v_nxt;
  msg_t       w_evt_msg;
  logic       w_evt;
  logic [2:0] r_prev_state;
  logic [7:0] r_txdata, w_txdata_nxt;
  logic       r_txclk, w_txclk_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_overrun, w_overrun_nxt;

  assign txdata  = r_txdata;
  assign txclk   = r_txclk;
  assign busy    = r_busy;
  assign overrun = r_overrun;

  function automatic logic [7:0] f_digit(input logic [3:0] nib);
    if (nib > 4'd9) return 8'h3F;
    return {4'h3, nib};
  endfunction

  function automatic logic [3:0] f_last(input kind_t kind);
    case (kind)
      K_START: return 4'd5;
      K_END:   return 4'd9;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [7:0] f_byte(input msg_t m, input logic [3:0] idx);
    case (m.kind)
      K_START: begin
        case (idx)
          4'd0:    return 8'h47;
          4'd1:    return 8'h4F;
          4'd2:    return 8'h20;
          4'd3:    return m.c0;
          4'd4:    return 8'h0D;
          default: return 8'h0A;
        endcase
      end
      K_END: begin
        case (idx)
          4'd0:    return 8'h53;
          4'd1:    return 8'h43;
          4'd2:    return 8'h4F;
          4'd3:    return 8'h52;
          4'd4:    return 8'h45;
          4'd5:    return 8'h20;
          4'd6:    return m.c0;
          4'd7:    return m.c1;
          4'd8:    return 8'h0D;
          default: return 8'h0A;
        endcase
      end
      default: begin
        case (idx)
          4'd0:    return m.c0;
          4'd1:    return 8'h0D;
          default: return 8'h0A;
        endcase
      end
    endcase
  endfunction

  // Classify a state change and snapshot the letter / score characters now.
  always_comb begin
    w_evt     = 1'b0;
    w_evt_msg = '{kind: K_START, c0: 8'h00, c1: 8'h00};
    if (state != r_prev_state) begin
      if (state == ST_OVER) begin
        w_evt         = 1'b1;
        w_evt_msg.kind = K_END;
        w_evt_msg.c0  = f_digit(score[7:4]);
        w_evt_msg.c1  = f_digit(score[3:0]);
      end else if (r_prev_state == ST_PRE) begin
        // state is 001..110 here: it differs from 000 and is not 111
        w_evt          = 1'b1;
        w_evt_msg.kind = K_START;
        w_evt_msg.c0   = 8'h40 + {5'b0, state};
      end
`ifdef NINETYNINE_LEVEL_ECHO_EN
      else if (r_prev_state != ST_OVER && state != ST_PRE) begin
        w_evt          = 1'b1;
        w_evt_msg.kind = K_ECHO;
        w_evt_msg.c0   = 8'h40 + {5'b0, state};
      end
`endif
    end
  end

  // Sequencer next state: message launch, byte strobes and pending-slot upkeep.
  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_idx_nxt     = r_idx;
    w_cur_nxt     = r_cur;
    w_pend_nxt    = r_pend;
    w_pend_v_nxt  = r_pend_v;
    w_txdata_nxt  = r_txdata;
    w_txclk_nxt   = 1'b0;
    w_overrun_nxt = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (r_pend_v) begin
          // pending message goes first; a simultaneous event takes the slot
          w_cur_nxt    = r_pend;
          w_idx_nxt    = 4'd0;
          w_fsm_nxt    = S_SEND;
          w_pend_v_nxt = w_evt;
          if (w_evt) w_pend_nxt = w_evt_msg;
        end else if (w_evt) begin
          w_cur_nxt = w_evt_msg;
          w_idx_nxt = 4'd0;
          w_fsm_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (txready) begin
          w_txdata_nxt = f_byte(r_cur, r_idx);
          w_txclk_nxt  = 1'b1;
          w_fsm_nxt    = S_GAP;
        end
      end
      S_GAP: begin
        if (r_idx == f_last(r_cur.kind)) begin
          w_fsm_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
          w_fsm_nxt = S_SEND;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
    if (r_fsm != S_IDLE && w_evt) begin
      w_pend_nxt    = w_evt_msg;
      w_pend_v_nxt  = 1'b1;
      w_overrun_nxt = r_pend_v;
    end
    w_busy_nxt = (w_fsm_nxt != S_IDLE);
  end

  // State and registered outputs; reset abandons any message and the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm        <= S_IDLE;
      r_idx        <= 4'd0;
      r_cur        <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_prev_state <= ST_PRE;
      r_txdata     <= 8'h00;
      r_txclk      <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_idx        <= w_idx_nxt;
      r_cur        <= w_cur_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_prev_state <= state;
      r_txdata     <= w_txdata_nxt;
      r_txclk      <= w_txclk_nxt;
      r_busy       <= w_busy_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

endmodule
